dmem_store_buffer: RTL

//  Sits directly downstream of the cardinal processor's Dmem port (DmemEn/DmemWrEn/Mem_Addr/Data_Out/Data_In).

---
 rtl/dmem_store_buffer.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/dmem_store_buffer.sv
// Store buffer between the processor Dmem port and a multi-cycle backing memory.
// Stores queue in a FIFO and drain in order; loads forward from the youngest match or stall for a backing read.
module dmem_store_buffer #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              dmem_en_i,
    input  logic              dmem_wr_en_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [DATA_W-1:0] data_out_i,
    output logic [DATA_W-1:0] data_in_c_o,
    output logic              dmem_stall_c_o,
    output logic [2:0]        buf_count_o,
    output logic              mem_req_o,
    output logic              mem_wr_o,
    output logic [ADDR_W-1:0] mem_req_addr_o,
    output logic [DATA_W-1:0] mem_wr_data_o,
    input  logic              mem_ack_i,
    input  logic [DATA_W-1:0] mem_rd_data_i
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } entry_t;

    typedef enum logic [1:0] {IDLE, WR_REQ, RD_REQ, RD_DONE} state_e;

    state_e            state_q, state_d;
    entry_t            buf_q [DEPTH];
    logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              mem_req_d, mem_wr_d;
    logic [ADDR_W-1:0] mem_req_addr_d;
    logic [DATA_W-1:0] mem_wr_data_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;

    logic              load_c, store_c, full_c, push_c, pop_c, hit_c, miss_c;
    logic [DATA_W-1:0] hit_data_c;

    assign load_c  = dmem_en_i & ~dmem_wr_en_i;
    assign store_c = dmem_en_i & dmem_wr_en_i;
    assign full_c  = (count_q == CNT_W'(DEPTH));
    assign push_c  = store_c & ~full_c;
    assign miss_c  = load_c & ~hit_c;

    // Scan oldest to youngest so the last match seen is the youngest one.
    always_comb begin
        logic [PTR_W-1:0] idx;
        idx        = '0;
        hit_c      = 1'b0;
        hit_data_c = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            idx = head_q + PTR_W'(k);
            if ((CNT_W'(k) < count_q) && (buf_q[idx].addr == mem_addr_i)) begin
                hit_c      = 1'b1;
                hit_data_c = buf_q[idx].data;
            end
        end
    end

    always_comb begin
        data_in_c_o = '0;
        if (state_q == RD_DONE) begin
            data_in_c_o = rd_data_q;
        end else if (load_c && hit_c) begin
            data_in_c_o = hit_data_c;
        end
    end

    // A full buffer refuses stores even when the head pops this cycle.
    assign dmem_stall_c_o = (store_c & full_c) | (miss_c & (state_q != RD_DONE));
    assign buf_count_o    = 3'(count_q);

    // Next state and registered backing-memory request.
    always_comb begin
        state_d        = state_q;
        mem_req_d      = mem_req_o;
        mem_wr_d       = mem_wr_o;
        mem_req_addr_d = mem_req_addr_o;
        mem_wr_data_d  = mem_wr_data_o;
        rd_data_d      = rd_data_q;
        pop_c          = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (miss_c) begin
                    state_d        = RD_REQ;
                    mem_req_d      = 1'b1;
                    mem_wr_d       = 1'b0;
                    mem_req_addr_d = mem_addr_i;
                end else if (count_q != '0) begin
                    state_d        = WR_REQ;
                    mem_req_d      = 1'b1;
                    mem_wr_d       = 1'b1;
                    mem_req_addr_d = buf_q[head_q].addr;
                    mem_wr_data_d  = buf_q[head_q].data;
                end
            end
            WR_REQ: begin
                if (mem_ack_i) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                    pop_c     = 1'b1;
                end
            end
            RD_REQ: begin
                if (mem_ack_i) begin
                    state_d   = RD_DONE;
                    mem_req_d = 1'b0;
                    rd_data_d = mem_rd_data_i;
                end
            end
            RD_DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        head_d  = head_q + PTR_W'(pop_c);
        tail_d  = tail_q + PTR_W'(push_c);
        count_d = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            head_q         <= '0;
            tail_q         <= '0;
            count_q        <= '0;
            rd_data_q      <= '0;
            mem_req_o      <= 1'b0;
            mem_wr_o       <= 1'b0;
            mem_req_addr_o <= '0;
            mem_wr_data_o  <= '0;
        end else begin
            state_q        <= state_d;
            head_q         <= head_d;
            tail_q         <= tail_d;
            count_q        <= count_d;
            rd_data_q      <= rd_data_d;
            mem_req_o      <= mem_req_d;
            mem_wr_o       <= mem_wr_d;
            mem_req_addr_o <= mem_req_addr_d;
            mem_wr_data_o  <= mem_wr_data_d;
        end
    end

    // Entry storage needs no reset: validity comes from head and count.
    always_ff @(posedge clk) begin
        if (push_c) begin
            buf_q[tail_q] <= {mem_addr_i, data_out_i};
        end
    end

endmodule
